// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage.
// Owns the PC and keeps at most one instruction-memory request in flight.
// Fills the IF/ID register, obeys the hazard-unit stalls, and handles redirects
// from EX, which take priority over any stall.
module instruction_fetch_stage #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int INSTR_WIDTH    = 32,
    parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inPCWrite,
    input  logic                      inIfIdWrite,
    input  logic                      inBranchTaken,
    input  logic [BUS_DATA_WIDTH-1:0] inBranchTarget,
    output logic                      outMemReqValid,
    output logic [BUS_DATA_WIDTH-1:0] outMemAddr,
    input  logic                      inMemReqReady,
    input  logic                      inMemRespValid,
    input  logic [INSTR_WIDTH-1:0]    inMemRespData,
    output logic                      outIfIdValid,
    output logic [INSTR_WIDTH-1:0]    outIfIdInstr,
    output logic [BUS_DATA_WIDTH-1:0] outIfIdPC,
    output logic [BUS_DATA_WIDTH-1:0] outIfIdPCPlus4
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,  // one cycle after reset, no request
        S_FETCH = 2'd1,  // request presented, waiting for acceptance
        S_WAIT  = 2'd2,  // request accepted, waiting for the response
        S_HOLD  = 2'd3   // response captured while IF/ID was stalled
    } fetchState_t;

    fetchState_t state, stateNext;

    // Architectural fetch state.
    logic [BUS_DATA_WIDTH-1:0] pc, pcNext;
    logic                      drop, dropNext;
    logic [INSTR_WIDTH-1:0]    holdBuf, holdBufNext;

    // IF/ID load control, produced by the FSM.
    logic                      loadIfId;
    logic [INSTR_WIDTH-1:0]    loadInstr;

    logic                      advance;
    logic [BUS_DATA_WIDTH-1:0] pcPlus4;
    logic [BUS_DATA_WIDTH-1:0] branchPC;

    // The low two target bits are forced to zero, so they are deliberately unused.
    logic unusedTgtBits;
    assign unusedTgtBits = ^inBranchTarget[1:0];

    // The pipeline moves only when both the PC and the IF/ID register may change.
    assign advance  = inPCWrite & inIfIdWrite;
    // Sequential PC, which wraps naturally at the width boundary.
    assign pcPlus4  = pc + BUS_DATA_WIDTH'(4);
    // The redirect target is word-aligned.
    assign branchPC = {inBranchTarget[BUS_DATA_WIDTH-1:2], 2'b00};

    // The request is a pure function of state, so it stays stable until accepted.
    assign outMemReqValid = (state == S_FETCH);
    assign outMemAddr     = pc;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= stateNext;
    end

    // Next-state, PC, drop flag and IF/ID load decisions
    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        dropNext    = drop;
        holdBufNext = holdBuf;
        loadIfId    = 1'b0;
        loadInstr   = inMemRespData;

        unique case (state)
            S_IDLE: begin
                stateNext = S_FETCH;
            end
            S_FETCH: begin
                if (inMemReqReady) stateNext = S_WAIT;
            end
            S_WAIT: begin
                if (inMemRespValid) begin
                    if (drop) begin
                        // The response belongs to a fetch killed by an earlier redirect.
                        dropNext  = 1'b0;
                        stateNext = S_FETCH;
                    end else if (advance) begin
                        loadIfId  = 1'b1;
                        loadInstr = inMemRespData;
                        pcNext    = pcPlus4;
                        stateNext = S_FETCH;
                    end else begin
                        // IF/ID is stalled, so park the instruction until it can move.
                        holdBufNext = inMemRespData;
                        stateNext   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (advance) begin
                    loadIfId  = 1'b1;
                    loadInstr = holdBuf;
                    pcNext    = pcPlus4;
                    stateNext = S_FETCH;
                end
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase

        // A redirect overrides everything above, including stalls.
        if (inBranchTaken) begin
            pcNext   = branchPC;
            loadIfId = 1'b0;
            unique case (state)
                S_IDLE: begin
                    stateNext = S_FETCH;
                end
                S_FETCH: begin
                    // If the old request is accepted on this edge, its response must be dropped.
                    if (inMemReqReady) begin
                        stateNext = S_WAIT;
                        dropNext  = 1'b1;
                    end else begin
                        stateNext = S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (inMemRespValid) begin
                        // A response on the redirect edge is simply discarded.
                        stateNext = S_FETCH;
                        dropNext  = 1'b0;
                    end else begin
                        stateNext = S_WAIT;
                        dropNext  = 1'b1;
                    end
                end
                S_HOLD: begin
                    stateNext = S_FETCH;
                end
                default: begin
                    stateNext = S_IDLE;
                end
            endcase
        end
    end

    // PC, drop flag and hold buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            drop    <= 1'b0;
            holdBuf <= '0;
        end else begin
            pc      <= pcNext;
            drop    <= dropNext;
            holdBuf <= holdBufNext;
        end
    end

    // IF/ID register: load, bubble on redirect or empty advance, else hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outIfIdValid   <= 1'b0;
            outIfIdInstr   <= '0;
            outIfIdPC      <= '0;
            outIfIdPCPlus4 <= '0;
        end else if (loadIfId) begin
            // The PC has not moved since this request was issued, so pc is its address.
            outIfIdValid   <= 1'b1;
            outIfIdInstr   <= loadInstr;
            outIfIdPC      <= pc;
            outIfIdPCPlus4 <= pcPlus4;
        end else if (inBranchTaken || inIfIdWrite) begin
            outIfIdValid   <= 1'b0;
        end
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
IF stage of the 5-stage pipeline, directly upstream of the ID-stage hazard detection unit. It owns the PC and issues one instruction-memory request at a time over a valid/ready request and valid response interface. It drives the IF/ID pipeline register and obeys the PC-write and IF/ID-write stall signals from the hazard unit. It also handles branch redirects and flushes from later stages.

Parameters:
BUS_DATA_WIDTH, 64, width of PC and instruction address
INSTR_WIDTH, 32, width of a fetched instruction
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
inPCWrite  input  1  from hazard unit; 0 = hold PC (stall)
inIfIdWrite  input  1  from hazard unit; 0 = hold IF/ID contents (stall)
inBranchTaken  input  1  redirect request from EX stage
inBranchTarget  input  BUS_DATA_WIDTH  redirect address
outMemReqValid  output  1  fetch request valid
outMemAddr  output  BUS_DATA_WIDTH  fetch address
inMemReqReady  input  1  memory accepts request
inMemRespValid  input  1  instruction data valid
inMemRespData  input  INSTR_WIDTH  returned instruction
outIfIdValid  output  1  IF/ID holds a real instruction
outIfIdInstr  output  INSTR_WIDTH  IF/ID instruction
outIfIdPC  output  BUS_DATA_WIDTH  PC of that instruction
outIfIdPCPlus4  output  BUS_DATA_WIDTH  that PC + 4

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- Reset values:
  - state=IDLE, pc=RESET_PC, drop=0, hold buffer=0.
  - outIfIdValid=0; outIfIdInstr=0; outIfIdPC=0; outIfIdPCPlus4=0.
  - outMemReqValid=0.
- Definitions:
  - advance = inPCWrite & inIfIdWrite.
  - Redirect (inBranchTaken=1) overrides any stall.
- FSM states:
  - IDLE: entered only from reset. Goes to FETCH on the next edge. No request.
  - FETCH: outMemReqValid=1, outMemAddr=pc. When inMemReqReady=1 on an edge, go to WAIT. Request must stay stable until accepted.
  - WAIT: waiting for inMemRespValid. On response:
    - If drop=1: discard the data, clear drop, go to FETCH.
    - Else if advance: load IF/ID (valid=1, instr, pc, pc+4), pc<=pc+4, go to FETCH.
    - Else: store the instruction in the hold buffer, go to HOLD.
  - HOLD: when advance, load IF/ID from the hold buffer, pc<=pc+4, go to FETCH.
- Bubble: on any edge with inIfIdWrite=1 and no instruction loaded, outIfIdValid<=0. The other IF/ID fields keep their old values.
- Stall: with inIfIdWrite=0, all IF/ID outputs hold. With inPCWrite=0, pc holds. Only one request is ever outstanding.
- Redirect (inBranchTaken=1 on an edge):
  - pc <= {inBranchTarget[BUS_DATA_WIDTH-1:2], 2'b00}; outIfIdValid <= 0.
  - FETCH with the request not accepted: stay in FETCH, using the new pc next cycle.
  - FETCH with the request accepted on the same edge: go to WAIT with drop=1.
  - WAIT without a response on that edge: drop<=1.
  - WAIT with a response on that edge: discard the response, go to FETCH.
  - HOLD: discard the buffer, go to FETCH.
  - IDLE: pc is updated, state still moves to FETCH.
- Arithmetic: pc+4 wraps modulo 2^BUS_DATA_WIDTH. outIfIdPCPlus4 is computed from the PC of the loaded instruction.
- Memory contract: a response may arrive no earlier than the cycle after acceptance. inMemRespValid outside WAIT is ignored.
- Reset mid-operation: all state clears immediately (asynchronously). A response pending at reset is ignored after reset, because the state is no longer WAIT.
- Throughput: at most one instruction every 2 cycles (FETCH then WAIT).

Test Plan:
1. Reset then straight-line fetch, ready=1, response 1 cycle after acceptance, advance=1 -> outMemAddr 0,4,8. IF/ID receives PC 0/4/8, PCPlus4 4/8/12, valid=1 on each load and 0 in between.
2. Load-use stall: inPCWrite=inIfIdWrite=0 for 3 cycles while the instruction at PC 0x10 arrives -> state HOLD. IF/ID is unchanged for those 3 cycles. On release, IF/ID gets PC 0x10 and the next request goes to 0x14.
3. Branch while in WAIT, target 0x203 -> drop=1. The late response is discarded, the next request goes to 0x200, and outIfIdValid=0 during the redirect cycle.
4. Branch on the same edge as the response -> the response is discarded, no IF/ID valid load, the next request goes to the target.
5. Back-pressure: inMemReqReady=0 for 4 cycles -> outMemReqValid=1 and outMemAddr stable at the same PC throughout. Exactly one request is accepted.
6. Wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> first IF/ID PCPlus4=0 and the second fetch address is 0. Asserting reset mid-WAIT returns all outputs to their reset values asynchronously.
